cache_driver: RTL and testbench
===============================

# cache_driver

Test sequencer that sits directly downstream of the cache-test instruction ROM and upstream of the cache under test. It steps the ROM index and converts each ROM entry into a cache request. It holds each request while the cache stalls, then advances. It counts cycles, hits and misses, and flags a stall timeout, so the bench can check the cycle budget of each test list (for example, 128 cycles for the standard list).

## Interface
- STALL_TIMEOUT, 64, maximum consecutive stall cycles on one request before it is flagged as an error
- CNT_WIDTH, 32, width of cycle_count

- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- index  output  4  ROM entry index currently presented
- inst_valid  input  1  ROM entry valid; 0 marks end of list
- inst_write  input  1  ROM entry is a write
- inst_addr  input  32  ROM entry byte address
- inst_u_b_h_w  input  3  ROM entry access size/sign code
- cache_en  output  1  request valid to cache
- cache_we  output  1  write request
- cache_addr  output  32  request address
- cache_u_b_h_w  output  3  request size code, passed through
- cache_din  output  32  write data
- cache_stall  input  1  cache busy; the request is not accepted while high
- done  output  1  sequence finished (sticky until reset)
- error  output  1  stall timeout occurred (sticky until reset)
- cycle_count  output  CNT_WIDTH  cycles spent with a request outstanding
- hit_count  output  16  requests completed without any stall cycle
- miss_count  output  16  requests completed after one or more stall cycles

## Operation
- FSM states: RUN, DONE. Reset enters RUN with index=0.
- Request outputs in RUN are combinational from the ROM:
  - cache_en = inst_valid
  - cache_we = inst_valid & inst_write
  - cache_addr = inst_addr
  - cache_u_b_h_w = inst_u_b_h_w
  - cache_din = {16'hA5A5, inst_addr[15:0]}
- In DONE, cache_en=0 and cache_we=0. The other request outputs keep following the ROM.
- RUN, inst_valid=0: next state is DONE and done<=1. Nothing is counted that cycle.
- RUN, inst_valid=1, cache_stall=1 (stall cycle):
  - cycle_count+1
  - stalled flag<=1
  - stall_cnt+1
  - index is held
- RUN, inst_valid=1, cache_stall=0 (completion cycle):
  - cycle_count+1
  - if stalled flag=1 then miss_count+1, else hit_count+1
  - stalled flag<=0, stall_cnt<=0
  - index<=index+1
- A dirty-eviction miss (two back-to-back fill/writeback stall periods) counts as one miss.
- End of ROM: a completion at index=15 sets done and enters DONE. Index does not wrap to 0.
- Timeout: when a stall cycle occurs with stall_cnt = STALL_TIMEOUT-1:
  - error<=1 and done<=1, next state is DONE
  - the aborted request is not counted as hit or miss
  - cycle_count still includes that cycle
- DONE is absorbing. Only reset leaves it. Counters freeze.
- Counters saturate at their all-ones value and do not wrap.

## Timing
- Reset values: index=0, done=0, error=0, cycle_count=0, hit_count=0, miss_count=0, stalled flag=0, stall_cnt=0, state=RUN.
- Request outputs reflect the ROM at index=0 combinationally once rst deasserts.
- Hit request: exactly 1 cycle. Miss with an N-cycle stall: N+1 cycles. The next entry is presented the cycle after completion.
- cache_stall is sampled on the rising edge. The cache must assert it in the same cycle the request appears.
- Reset asserted mid-request: all registers clear immediately (asynchronous). cache_en follows the ROM at index 0 after release. No partial count is retained.
- done/error rise one cycle after the terminating condition is sampled.

## Test plan
- Standard list against a cache model that has a 17-cycle miss stall (34 for a dirty miss):
  - done rises one cycle after index reaches 9
  - cycle_count=128, hit_count=3, miss_count=6, error=0
- All-hit stub (cache_stall tied 0), 9 valid entries then an end entry: cycle_count=9, hit_count=9, miss_count=0, index=9, done=1.
- cache_stall stuck high on entry 0, STALL_TIMEOUT=64: error=1 and done=1 after 64 cycles; cycle_count=64, hit_count=0, miss_count=0, index=0.
- ROM with all 16 entries valid, no stalls: done=1 after 16 cycles, index stays 15, cycle_count=16.
- rst pulsed low during the 10th stall cycle of entry 1: all outputs return to 0 asynchronously. The sequence restarts from index 0 and a full rerun reproduces cycle_count=128.
- Write entry at address 0x19: while the entry is presented, cache_we=1, cache_addr=0x00000019, cache_din=0xA5A50019, cache_u_b_h_w=3'b000.

Source files
------------

// File: rtl/cache_driver.sv
// rtl/cache_driver.sv - steps the cache-test ROM, issues cache requests, counts cycles/hits/misses
// Holds each request through cache stalls; a stall run reaching STALL_TIMEOUT aborts the list.
module cache_driver #(
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [3:0]           index,
  input  logic                 inst_valid,
  input  logic                 inst_write,
  input  logic [31:0]          inst_addr,
  input  logic [2:0]           inst_u_b_h_w,
  output logic                 cache_en,
  output logic                 cache_we,
  output logic [31:0]          cache_addr,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_stall,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam logic RUN  = 1'b0;
  localparam logic DONE = 1'b1;

  localparam int SW = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

  logic                 r_state;
  logic [3:0]           r_index;
  logic                 r_done;
  logic                 r_error;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [15:0]          r_hit_count;
  logic [15:0]          r_miss_count;
  logic                 r_stalled;
  logic [SW-1:0]        r_stall_cnt;

  logic w_run;

  assign w_run = (r_state == RUN);

  // Request path is combinational from the ROM so a hit completes in the cycle it is presented.
  assign cache_en      = w_run & inst_valid;
  assign cache_we      = w_run & inst_valid & inst_write;
  assign cache_addr    = inst_addr;
  assign cache_u_b_h_w = inst_u_b_h_w;
  assign cache_din     = {16'hA5A5, inst_addr[15:0]};

  assign index       = r_index;
  assign done        = r_done;
  assign error       = r_error;
  assign cycle_count = r_cycle_count;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_index       <= 4'd0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cycle_count <= '0;
      r_hit_count   <= 16'd0;
      r_miss_count  <= 16'd0;
      r_stalled     <= 1'b0;
      r_stall_cnt   <= '0;
    end else if (r_state == RUN) begin
      if (!inst_valid) begin
        r_state <= DONE;
        r_done  <= 1'b1;
      end else begin
        if (r_cycle_count != {CNT_WIDTH{1'b1}}) begin
          r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
        end
        if (cache_stall) begin
          r_stalled <= 1'b1;
          // The aborted request is never credited as a hit or miss.
          if (r_stall_cnt == STALL_LAST) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
          end
        end else begin
          if (r_stalled) begin
            if (r_miss_count != 16'hFFFF) begin
              r_miss_count <= r_miss_count + 16'd1;
            end
          end else begin
            if (r_hit_count != 16'hFFFF) begin
              r_hit_count <= r_hit_count + 16'd1;
            end
          end
          r_stalled   <= 1'b0;
          r_stall_cnt <= '0;
          if (r_index == 4'hF) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_index <= r_index + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_driver.sv
// tb/tb_cache_driver.sv - directed bench for cache_driver with a ROM table and stall-length cache model
module tb_cache_driver;

  logic        clk;
  logic        rst;
  logic [3:0]  index;
  logic        inst_valid;
  logic        inst_write;
  logic [31:0] inst_addr;
  logic [2:0]  inst_u_b_h_w;
  logic        cache_en;
  logic        cache_we;
  logic [31:0] cache_addr;
  logic [2:0]  cache_u_b_h_w;
  logic [31:0] cache_din;
  logic        cache_stall;
  logic        done;
  logic        error;
  logic [31:0] cycle_count;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        rom_valid [16];
  logic        rom_write [16];
  logic [31:0] rom_addr  [16];
  logic [2:0]  rom_ubhw  [16];
  int          rom_stall [16];

  int checks = 0;
  int errors = 0;
  int stall_mode;
  int scnt;
  int n;

  cache_driver #(.STALL_TIMEOUT(64), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .index(index),
    .inst_valid(inst_valid), .inst_write(inst_write), .inst_addr(inst_addr),
    .inst_u_b_h_w(inst_u_b_h_w),
    .cache_en(cache_en), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din), .cache_stall(cache_stall),
    .done(done), .error(error), .cycle_count(cycle_count),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_valid   = rom_valid[index];
  assign inst_write   = rom_write[index];
  assign inst_addr    = rom_addr[index];
  assign inst_u_b_h_w = rom_ubhw[index];

  // Cache model: mode 0 stalls each entry for its table length, 1 never stalls, 2 stalls forever.
  assign cache_stall = (stall_mode == 2) ? 1'b1 :
                       (stall_mode == 1) ? 1'b0 : (scnt < rom_stall[index]);

  always @(posedge clk or negedge rst) begin
    if (!rst) scnt <= 0;
    else if (cache_en) scnt <= cache_stall ? scnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_done(input int max, output int cnt);
    cnt = 0;
    while (!done && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_index(input logic [3:0] idx, input int max, inout int cnt);
    int k = 0;
    while (index != idx && k < max) begin
      @(negedge clk);
      cnt++;
      k++;
    end
    check("index_reached", {60'd0, index}, {60'd0, idx});
  endtask

  task automatic load_standard();
    int stl [9] = '{17, 17, 0, 17, 34, 0, 17, 17, 0};
    for (int i = 0; i < 16; i++) begin
      rom_valid[i] = (i < 9);
      rom_write[i] = 1'b0;
      rom_addr[i]  = 32'h100 + 32'(i * 4);
      rom_ubhw[i]  = 3'b010;
      rom_stall[i] = (i < 9) ? stl[i] : 0;
    end
    rom_write[3] = 1'b1;
    rom_addr[3]  = 32'h19;
    rom_ubhw[3]  = 3'b000;
  endtask

  task automatic run_standard(input bit check_write);
    n = 0;
    if (check_write) begin
      wait_index(4'd3, 200, n);
      check("wr_we",   {63'd0, cache_we}, 64'd1);
      check("wr_en",   {63'd0, cache_en}, 64'd1);
      check("wr_addr", {32'd0, cache_addr}, 64'h19);
      check("wr_din",  {32'd0, cache_din}, 64'hA5A50019);
      check("wr_ubhw", {61'd0, cache_u_b_h_w}, 64'd0);
    end
    wait_index(4'd9, 400, n);
    check("std_idx9_time", 64'(n), 64'd128);
    check("std_done_low_at_idx9", {63'd0, done}, 64'd0);
    @(negedge clk);
    n++;
    check("std_done_next", {63'd0, done}, 64'd1);
    check("std_cycles", {32'd0, cycle_count}, 64'd128);
    check("std_hits",   {48'd0, hit_count}, 64'd3);
    check("std_misses", {48'd0, miss_count}, 64'd6);
    check("std_error",  {63'd0, error}, 64'd0);
    check("std_en_off", {63'd0, cache_en}, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    stall_mode = 0;
    load_standard();
    do_reset();

    check("rst_index",  {60'd0, index}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_error",  {63'd0, error}, 64'd0);
    check("rst_cycles", {32'd0, cycle_count}, 64'd0);
    check("rst_hits",   {48'd0, hit_count}, 64'd0);
    check("rst_misses", {48'd0, miss_count}, 64'd0);
    check("rst_en",     {63'd0, cache_en}, 64'd1);
    check("rst_addr",   {32'd0, cache_addr}, 64'h100);

    run_standard(1'b1);

    // Reset during the 10th stall cycle of entry 1, then a clean rerun.
    do_reset();
    n = 0;
    while (!(index == 4'd1 && scnt == 9) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", {63'd0, (index == 4'd1 && scnt == 9)}, 64'd1);
    check("mid_cycles_pre", {32'd0, cycle_count}, 64'd27);
    rst = 1'b0;
    #1;
    check("mid_index",  {60'd0, index}, 64'd0);
    check("mid_cycles", {32'd0, cycle_count}, 64'd0);
    check("mid_misses", {48'd0, miss_count}, 64'd0);
    check("mid_done",   {63'd0, done}, 64'd0);
    check("mid_en",     {63'd0, cache_en}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    run_standard(1'b0);

    // All-hit stub on the 9-entry list.
    stall_mode = 1;
    do_reset();
    run_until_done(50, n);
    check("hit_time",   64'(n), 64'd10);
    check("hit_cycles", {32'd0, cycle_count}, 64'd9);
    check("hit_hits",   {48'd0, hit_count}, 64'd9);
    check("hit_misses", {48'd0, miss_count}, 64'd0);
    check("hit_index",  {60'd0, index}, 64'd9);

    // Stall stuck high on entry 0.
    stall_mode = 2;
    do_reset();
    run_until_done(200, n);
    check("to_time",   64'(n), 64'd64);
    check("to_error",  {63'd0, error}, 64'd1);
    check("to_cycles", {32'd0, cycle_count}, 64'd64);
    check("to_hits",   {48'd0, hit_count}, 64'd0);
    check("to_misses", {48'd0, miss_count}, 64'd0);
    check("to_index",  {60'd0, index}, 64'd0);

    // Full 16-entry ROM, no stalls: stops at index 15 without wrapping.
    stall_mode = 1;
    for (int i = 0; i < 16; i++) rom_valid[i] = 1'b1;
    do_reset();
    run_until_done(50, n);
    check("full_time", 64'(n), 64'd16);
    repeat (5) @(negedge clk);
    check("full_index",  {60'd0, index}, 64'd15);
    check("full_cycles", {32'd0, cycle_count}, 64'd16);
    check("full_hits",   {48'd0, hit_count}, 64'd16);
    check("full_error",  {63'd0, error}, 64'd0);
    check("full_en_off", {63'd0, cache_en}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
